// File: rtl/pair_vec_packer_if.sv
// Stream bundle for pair_vec_packer: narrow element beats in, one flat vector out.
// The master modport is the producer/consumer side and the slave modport is the packer itself.
interface pair_vec_packer_if #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int VEC_LEN = 64
);
  logic                        i_s_valid;
  logic                        o_s_ready;
  logic [DATA_W*LANES-1:0]     i_s_data;
  logic                        i_s_last;
  logic                        o_valid;
  logic                        i_ready;
  logic [DATA_W*VEC_LEN-1:0]   o_data_flat;

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_ready,
    input  o_s_ready, o_valid, o_data_flat
  );

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_ready,
    output o_s_ready, o_valid, o_data_flat
  );
endinterface

// File: rtl/pair_vec_packer.sv
// Packs LANES-wide beats of signed elements into VEC_LEN-element vectors for the pair mean/variance stage.
// Optional macro PAIR_PACK_ZERO_PAD_EN: an early last zero-pads the vector instead of dropping it.
module pair_vec_packer #(
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int VEC_LEN = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pair_vec_packer_if.slave    bus,
  output logic                o_err,
  output logic [15:0]         o_vec_cnt
);
  localparam int BPV    = VEC_LEN / LANES;
  localparam int CNT_W  = (BPV > 1) ? $clog2(BPV) : 1;
  localparam int BEAT_W = DATA_W * LANES;
  localparam int VEC_W  = DATA_W * VEC_LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPV - 1);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [VEC_W-1:0]   pack_r;
  logic [VEC_W-1:0]   out_r;
  logic               valid_r;
  logic               err_r;
  logic               err_s;
  logic [15:0]        vec_cnt_r;
  logic               accept_s;
  logic               slot_free_s;
  logic               load_s;
  logic               pad_s;

  assign accept_s    = bus.i_s_valid && (state_r == FILL);
  assign slot_free_s = !valid_r || bus.i_ready;

  // Next-state, beat counter and error decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = 1'b0;
    load_s  = 1'b0;
    pad_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          if (cnt_r == LAST_CNT) begin
            state_s = HOLD;
            cnt_s   = {CNT_W{1'b0}};
            err_s   = !bus.i_s_last;
          end else if (bus.i_s_last) begin
`ifdef PAIR_PACK_ZERO_PAD_EN
            state_s = HOLD;
            cnt_s   = {CNT_W{1'b0}};
            pad_s   = 1'b1;
`else
            cnt_s   = {CNT_W{1'b0}};
            err_s   = 1'b1;
`endif
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          load_s  = 1'b1;
          state_s = FILL;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = FILL;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= FILL;
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
    end
  end

  // Pack register: current beat lands in its slot; later slots zeroed on a padded early last
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pack_r <= {VEC_W{1'b0}};
    end else if (accept_s) begin
      for (int b = 0; b < BPV; b++) begin
        if (cnt_r == CNT_W'(b)) begin
          pack_r[b*BEAT_W +: BEAT_W] <= bus.i_s_data;
        end else if (pad_s && (CNT_W'(b) > cnt_r)) begin
          pack_r[b*BEAT_W +: BEAT_W] <= {BEAT_W{1'b0}};
        end
      end
    end
  end

  // Output slot: a transfer from HOLD wins over a plain handshake so back-to-back vectors keep valid high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_r     <= {VEC_W{1'b0}};
      valid_r   <= 1'b0;
      vec_cnt_r <= 16'd0;
    end else if (load_s) begin
      out_r     <= pack_r;
      valid_r   <= 1'b1;
      vec_cnt_r <= vec_cnt_r + 16'd1;
    end else if (valid_r && bus.i_ready) begin
      valid_r   <= 1'b0;
    end
  end

  assign bus.o_s_ready   = (state_r == FILL);
  assign bus.o_valid     = valid_r;
  assign bus.o_data_flat = out_r;
  assign o_err           = err_r;
  assign o_vec_cnt       = vec_cnt_r;
endmodule

// File: tb/tb_pair_vec_packer.sv
// Directed self-checking bench for pair_vec_packer (default parameters).
module tb_pair_vec_packer;
  localparam int DATA_W  = 16;
  localparam int LANES   = 4;
  localparam int VEC_LEN = 64;
  localparam int BPV     = VEC_LEN / LANES;
  localparam int BEAT_W  = DATA_W * LANES;
  localparam int VW      = DATA_W * VEC_LEN;

  logic        clk;
  logic        rst_n;
  logic        o_err;
  logic [15:0] o_vec_cnt;
  int          pass_cnt;
  int          fail_cnt;
  int          err_total;
  int          valid_total;
  int          err_base;
  int          valid_base;
  logic [VW-1:0] exp_v;

  pair_vec_packer_if #(.DATA_W(DATA_W), .LANES(LANES), .VEC_LEN(VEC_LEN)) bus ();

  pair_vec_packer #(.DATA_W(DATA_W), .LANES(LANES), .VEC_LEN(VEC_LEN)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .o_err     (o_err),
    .o_vec_cnt (o_vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_err === 1'b1) err_total++;
    if (bus.o_valid === 1'b1) valid_total++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    int idx;
    idx = -1;
    for (int k = VEC_LEN - 1; k >= 0; k--)
      if (obs[k*DATA_W +: DATA_W] !== expv[k*DATA_W +: DATA_W]) idx = k;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      if (idx < 0) idx = 0;
      $error("FAIL %s: element %0d got %h expected %h", tag, idx,
             obs[idx*DATA_W +: DATA_W], expv[idx*DATA_W +: DATA_W]);
    end
  endtask

  function automatic logic [VW-1:0] make_vec(input logic [15:0] base, input logic [15:0] step);
    logic [VW-1:0] v;
    for (int k = 0; k < VEC_LEN; k++) v[k*DATA_W +: DATA_W] = base + 16'(k) * step;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic [BEAT_W-1:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = d;
    bus.i_s_last  = last;
    while (bus.o_s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail_cnt++;
      $display("FAIL beat_timeout: o_s_ready stayed low for %0d cycles, required 1 within 100", n);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [VW-1:0] v, input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) beat(v[b*BEAT_W +: BEAT_W], b == last_at);
  endtask

  // Called right after the final beat edge (cycle T); expects valid in T+2 for one cycle with ready high.
  task automatic chk_emit(input string tag, input logic [VW-1:0] expv);
    chk({tag, "_valid_T"}, {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid_T1"}, {31'd0, bus.o_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid_T2"}, {31'd0, bus.o_valid}, 32'd1);
    chk_vec({tag, "_data"}, bus.o_data_flat, expv);
    @(negedge clk);
    chk({tag, "_valid_drop"}, {31'd0, bus.o_valid}, 32'd0);
    chk_vec({tag, "_data_kept"}, bus.o_data_flat, expv);
  endtask

  initial begin
    pass_cnt = 0;
    fail_cnt = 0;
    rst_n = 1'b0;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    bus.i_s_last  = 1'b0;
    bus.i_ready   = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_vec_cnt", {16'd0, o_vec_cnt}, 32'd0);
    chk("rst_ready", {31'd0, bus.o_s_ready}, 32'd1);
    chk_vec("rst_data", bus.o_data_flat, {VW{1'b0}});
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: element k = k
    bus.i_ready = 1'b1;
    err_base = err_total;
    exp_v = make_vec(16'h0000, 16'h0001);
    send_vec(exp_v, BPV, BPV - 1);
    chk_emit("basic", exp_v);
    chk("basic_vec_cnt", {16'd0, o_vec_cnt}, 32'd1);
    chk("basic_no_err", err_total - err_base, 32'd0);

    // Backpressure: A parks on the output, B parks in HOLD
    do_reset();
    bus.i_ready = 1'b0;
    send_vec(make_vec(16'h1111, 16'h0000), BPV, BPV - 1);
    send_vec(make_vec(16'h2222, 16'h0000), BPV, BPV - 1);
    repeat (3) @(negedge clk);
    chk("bp_ready_low", {31'd0, bus.o_s_ready}, 32'd0);
    chk("bp_a_valid", {31'd0, bus.o_valid}, 32'd1);
    chk_vec("bp_a_data", bus.o_data_flat, make_vec(16'h1111, 16'h0000));
    chk("bp_a_cnt", {16'd0, o_vec_cnt}, 32'd1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", {31'd0, bus.o_valid}, 32'd1);
    chk_vec("bp_b_data", bus.o_data_flat, make_vec(16'h2222, 16'h0000));
    chk("bp_b_cnt", {16'd0, o_vec_cnt}, 32'd2);
    chk("bp_ready_back", {31'd0, bus.o_s_ready}, 32'd1);
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("bp_b_done", {31'd0, bus.o_valid}, 32'd0);
    chk_vec("bp_b_kept", bus.o_data_flat, make_vec(16'h2222, 16'h0000));

`ifdef PAIR_PACK_ZERO_PAD_EN
    // Zero pad: 5 beats of 0x7FFF, last on beat 4
    do_reset();
    bus.i_ready = 1'b1;
    err_base = err_total;
    exp_v = {VW{1'b0}};
    for (int k = 0; k < 5 * LANES; k++) exp_v[k*DATA_W +: DATA_W] = 16'h7FFF;
    send_vec(make_vec(16'h7FFF, 16'h0000), 5, 4);
    chk_emit("pad", exp_v);
    chk("pad_vec_cnt", {16'd0, o_vec_cnt}, 32'd1);
    chk("pad_no_err", err_total - err_base, 32'd0);
`else
    // Early last on beat 5: error pulse, vector dropped
    do_reset();
    bus.i_ready = 1'b1;
    err_base = err_total;
    valid_base = valid_total;
    send_vec(make_vec(16'h4000, 16'h0001), 6, 5);
    @(negedge clk);
    chk("early_err_hi", {31'd0, o_err}, 32'd1);
    @(negedge clk);
    chk("early_err_lo", {31'd0, o_err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("early_no_valid", valid_total - valid_base, 32'd0);
    exp_v = make_vec(16'h8000, 16'h0001);
    send_vec(exp_v, BPV, BPV - 1);
    chk_emit("early_next", exp_v);
    chk("early_vec_cnt", {16'd0, o_vec_cnt}, 32'd1);
    chk("early_err_once", err_total - err_base, 32'd1);
`endif

    // Missing last: vector still emitted, one error pulse
    do_reset();
    bus.i_ready = 1'b1;
    err_base = err_total;
    exp_v = make_vec(16'h0100, 16'h0003);
    send_vec(exp_v, BPV, -1);
    chk_emit("miss", exp_v);
    chk("miss_err_once", err_total - err_base, 32'd1);
    chk("miss_vec_cnt", {16'd0, o_vec_cnt}, 32'd1);

    // Reset mid-fill: asynchronous clear, then a clean vector
    send_vec(make_vec(16'h5555, 16'h0001), 7, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, o_vec_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.o_s_ready}, 32'd1);
    chk_vec("mid_rst_data", bus.o_data_flat, {VW{1'b0}});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = make_vec(16'hFFFF, 16'h0000);
    send_vec(exp_v, BPV, BPV - 1);
    chk_emit("post_rst", exp_v);
    chk("post_rst_cnt", {16'd0, o_vec_cnt}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end
endmodule

// File: doc/pair_vec_packer.md
Name: pair_vec_packer

Overview:
- Transmitter side of the LayerNorm pair statistics input interface.
- Accepts a narrow valid/ready stream of signed 16-bit elements and packs VEC_LEN elements into one flat vector.
- Presents the vector as a valid/ready output (o_valid, o_data_flat) to the pair variance/mean stage.
- Double-buffered: one pack register fills while the previously completed vector waits on the output register.

Parameters:
- DATA_W, 16, element width in bits.
- LANES, 4, elements per input beat; must divide VEC_LEN.
- VEC_LEN, 64, elements per output vector; BPV = VEC_LEN/LANES beats per vector (16 by default).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_s_valid  in  1  input beat valid.
- o_s_ready  out  1  input beat ready.
- i_s_data  in  DATA_W*LANES  beat payload; lane j in bits [DATA_W*j +: DATA_W].
- i_s_last  in  1  marks final beat of a vector.
- o_valid  out  1  output vector valid.
- i_ready  in  1  downstream accepts vector.
- o_data_flat  out  DATA_W*VEC_LEN  packed vector; element k in bits [DATA_W*k +: DATA_W].
- o_err  out  1  one-cycle pulse on framing error.
- o_vec_cnt  out  16  count of vectors handed off.

Behaviour:
- Reset asserted, asynchronously: state=FILL, beat cnt=0, pack register=0, o_valid=0, o_data_flat=0, o_err=0, o_vec_cnt=0. Any partial vector is discarded.
- Beat accept: i_s_valid && o_s_ready. o_s_ready = (state==FILL), combinational.
- On accept, lane j of beat cnt is written to pack element cnt*LANES+j, and cnt increments.
- State FILL:
  - Accepted beat with cnt==BPV-1 -> HOLD, cnt<=0.
  - If i_s_last=0 on that beat, o_err pulses next cycle; the vector is still completed.
  - Accepted beat with i_s_last=1 and cnt<BPV-1 (early last) -> o_err pulses next cycle, partial vector dropped, cnt<=0, stay in FILL.
  - Pack register contents are not cleared on a drop; every element is overwritten by the next full vector.
- State HOLD, output slot free (!o_valid || i_ready): output register <= pack register, o_valid<=1, o_vec_cnt++ (wraps at 16 bits), state -> FILL.
- State HOLD, slot not free: stay in HOLD; o_s_ready=0.
- Output handshake: o_valid && i_ready.
  - With no HOLD transfer in the same cycle, o_valid<=0 next cycle.
  - With a HOLD transfer in the same cycle, o_valid stays 1 with the new data (back-to-back).
- o_valid and o_data_flat stay stable while o_valid && !i_ready.
- Latency: final beat accepted in cycle T with a free slot -> o_valid=1 in cycle T+2.
- Throughput: BPV+1 cycles per vector.
- o_data_flat keeps its last value after the handshake; it is not cleared.

Optional Feature:
- Macro PAIR_PACK_ZERO_PAD_EN.
- Defined: an early i_s_last does not raise an error. The remaining elements of that vector are forced to 0, and state -> HOLD as for a complete vector.
- Undefined: early last is dropped with an o_err pulse, as specified in Behaviour.

Test Plan:
- Basic: defaults, i_ready=1, 16 beats carrying element k=k, i_s_last on beat 15 -> o_valid high for exactly 1 cycle at T+2, o_data_flat[16k+:16]==k for all k, o_vec_cnt==1, o_err never pulses.
- Backpressure: i_ready=0, send vectors A (all 0x1111) and B (all 0x2222).
  - A sits on the output; B reaches HOLD; o_s_ready==0.
  - Raise i_ready for 2 cycles -> A handshakes, then B is valid the next cycle.
  - o_vec_cnt==2; no data corruption.
- Early last: i_s_last on beat 5 -> o_err pulses 1 cycle, no o_valid. Next full vector with elements 0x8000+k is emitted exactly, o_vec_cnt==1.
- Missing last: 16 beats with i_s_last=0 throughout -> o_err pulses once, and the vector is still emitted with correct data.
- Reset mid-fill: after 7 beats, pulse i_rst_n low for 1 cycle.
  - Outputs return to reset values immediately.
  - Then 16 beats of 0xFFFF -> vector of all 0xFFFF, o_vec_cnt==1.
- PAIR_PACK_ZERO_PAD_EN: 5 beats of 0x7FFF with i_s_last on beat 4 -> elements 0..19==0x7FFF, 20..63==0, o_valid at T+2, no o_err.
